// File: rtl/sata_link_rx_deframer.sv
// sata_link_rx_deframer
// Receive-side SATA link-layer deframer. Detects SOF/EOF, descrambles the
// data dwords of a frame, drops CONT junk and primitives, and holds back
// two dwords so that the trailing CRC dword is never delivered as payload.
// At EOF the CRC-32 over the delivered payload is compared against the held
// CRC dword, and a one-cycle status strobe reports the frame outcome.
module sata_link_rx_deframer #(
   parameter int unsigned MAX_DW    = 2049,
   parameter logic [15:0] LFSR_SEED = 16'hF0F6,
   parameter logic [31:0] CRC_INIT  = 32'h52325032
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] rx_data,
   input  logic [3:0]  rx_isk,
   input  logic        rx_valid,
   output logic [31:0] m_data,
   output logic        m_valid,
   output logic        m_sof,
   output logic        m_last,
   output logic        frm_done,
   output logic        frm_crc_ok,
   output logic        frm_err,
   output logic        busy
);

   // Primitive encodings (byte 0 carries the K character).
   localparam logic [31:0] PRIM_SOF  = 32'h3737B57C;
   localparam logic [31:0] PRIM_EOF  = 32'hD5D5B57C;
   localparam logic [31:0] PRIM_CONT = 32'h9999AA7C;
   localparam logic [31:0] PRIM_SYNC = 32'hB5B5957C;
   localparam logic [31:0] CRC_POLY  = 32'h04C11DB7;

   localparam int unsigned        CNT_W    = $clog2(MAX_DW + 2);
   localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_DW);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      SKIP  = 2'd2
   } state_t;

   // What the current rx beat means for the frame, decided before acting.
   typedef enum logic [2:0] {
      EV_NONE     = 3'd0,
      EV_START    = 3'd1,
      EV_RESTART  = 3'd2,
      EV_ABORT    = 3'd3,
      EV_CLOSE    = 3'd4,
      EV_TAKE     = 3'd5,
      EV_TO_SKIP  = 3'd6,
      EV_TO_FRAME = 3'd7
   } event_t;

   // Scrambler keystream for one dword. The 16-bit context holds the last
   // 16 keystream bits (bit 15 newest); each new bit obeys
   // o[n+16] = o[n+15] ^ o[n+13] ^ o[n+4] ^ o[n], which is the output
   // sequence of G(X)=X16+X15+X13+X4+1. Bit 0 of the result is the first
   // bit produced; the new context is result[31:16].
   function automatic logic [31:0] scr_keystream(input logic [15:0] ctx);
      logic [15:0] w;
      logic [31:0] o;
      logic        nb;
      w = ctx;
      o = 32'h0000_0000;
      for (int i = 0; i < 32; i++) begin
         nb = w[15] ^ w[13] ^ w[4] ^ w[0];
         w  = {nb, w[15:1]};
         o  = {nb, o[31:1]};
      end
      return o;
   endfunction

   // CRC-32 update with one dword, MSB first, non-reflected.
   function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                              input logic [31:0] d);
      logic [31:0] c;
      c = crc ^ d;
      for (int i = 0; i < 32; i++) begin
         c = c[31] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

   state_t            state_r, state_s;
   event_t            ev_s;
   logic [31:0]       h0_r, h0_s;
   logic [31:0]       h1_r, h1_s;
   logic [1:0]        hcnt_r, hcnt_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [15:0]       lfsr_r, lfsr_s;
   logic [31:0]       crc_r, crc_s;
   logic              first_r, first_s;

   logic [31:0]       m_data_s;
   logic              m_valid_s, m_sof_s, m_last_s;
   logic              frm_done_s, frm_crc_ok_s, frm_err_s;

   logic [31:0]       keystream_s;
   logic [31:0]       descr_s;
   logic [31:0]       crc_fold_s;
   logic              is_prim_s;
   logic              is_data_s;

   assign keystream_s = scr_keystream(lfsr_r);
   assign descr_s     = rx_data ^ keystream_s;
   assign crc_fold_s  = crc32_step(crc_r, h0_r);
   assign is_prim_s   = (rx_isk == 4'b0001);
   assign is_data_s   = (rx_isk == 4'b0000);

   // State and datapath registers; every output is registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         h0_r       <= 32'h0000_0000;
         h1_r       <= 32'h0000_0000;
         hcnt_r     <= 2'd0;
         cnt_r      <= CNT_ZERO;
         lfsr_r     <= LFSR_SEED;
         crc_r      <= CRC_INIT;
         first_r    <= 1'b0;
         m_data     <= 32'h0000_0000;
         m_valid    <= 1'b0;
         m_sof      <= 1'b0;
         m_last     <= 1'b0;
         frm_done   <= 1'b0;
         frm_crc_ok <= 1'b0;
         frm_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_r    <= state_s;
         h0_r       <= h0_s;
         h1_r       <= h1_s;
         hcnt_r     <= hcnt_s;
         cnt_r      <= cnt_s;
         lfsr_r     <= lfsr_s;
         crc_r      <= crc_s;
         first_r    <= first_s;
         m_data     <= m_data_s;
         m_valid    <= m_valid_s;
         m_sof      <= m_sof_s;
         m_last     <= m_last_s;
         frm_done   <= frm_done_s;
         frm_crc_ok <= frm_crc_ok_s;
         frm_err    <= frm_err_s;
         busy       <= (state_s != IDLE);
      end
   end

   // Classify the rx beat, then compute next state, holdback and outputs.
   always_comb begin
      ev_s         = EV_NONE;
      state_s      = state_r;
      h0_s         = h0_r;
      h1_s         = h1_r;
      hcnt_s       = hcnt_r;
      cnt_s        = cnt_r;
      lfsr_s       = lfsr_r;
      crc_s        = crc_r;
      first_s      = first_r;
      m_data_s     = m_data;
      m_valid_s    = 1'b0;
      m_sof_s      = 1'b0;
      m_last_s     = 1'b0;
      frm_done_s   = 1'b0;
      frm_crc_ok_s = 1'b0;
      frm_err_s    = 1'b0;

      // Beat classification; invalid beats leave everything untouched.
      if (rx_valid) begin
         case (state_r)
            IDLE: begin
               if (is_prim_s && (rx_data == PRIM_SOF)) begin
                  ev_s = EV_START;
               end else begin
                  ev_s = EV_NONE;
               end
            end
            FRAME, SKIP: begin
               if (is_prim_s) begin
                  case (rx_data)
                     PRIM_SOF:  ev_s = EV_RESTART;
                     PRIM_EOF:  ev_s = EV_CLOSE;
                     PRIM_SYNC: ev_s = EV_ABORT;
                     PRIM_CONT: ev_s = EV_TO_SKIP;
                     default:   ev_s = EV_TO_FRAME;
                  endcase
               end else if (is_data_s) begin
                  if (state_r == SKIP) begin
                     ev_s = EV_NONE;          // CONT junk: no LFSR step
                  end else if (cnt_r >= CNT_MAX) begin
                     ev_s = EV_ABORT;         // frame longer than MAX_DW
                  end else begin
                     ev_s = EV_TAKE;
                  end
               end else begin
                  ev_s = EV_ABORT;            // code error
               end
            end
            default: ev_s = EV_ABORT;
         endcase
      end else begin
         ev_s = EV_NONE;
      end

      case (ev_s)
         EV_START: begin
            state_s = FRAME;
            lfsr_s  = LFSR_SEED;
            crc_s   = CRC_INIT;
            hcnt_s  = 2'd0;
            cnt_s   = CNT_ZERO;
            first_s = 1'b1;
         end
         EV_RESTART: begin
            // Report the killed frame and start the new one on the same beat.
            frm_done_s = 1'b1;
            frm_err_s  = 1'b1;
            state_s    = FRAME;
            lfsr_s     = LFSR_SEED;
            crc_s      = CRC_INIT;
            hcnt_s     = 2'd0;
            cnt_s      = CNT_ZERO;
            first_s    = 1'b1;
         end
         EV_ABORT: begin
            frm_done_s = 1'b1;
            frm_err_s  = 1'b1;
            state_s    = IDLE;
            hcnt_s     = 2'd0;
         end
         EV_CLOSE: begin
            frm_done_s = 1'b1;
            state_s    = IDLE;
            hcnt_s     = 2'd0;
            if (hcnt_r == 2'd2) begin
               // h0 is the last payload dword, h1 is the CRC dword.
               m_data_s     = h0_r;
               m_valid_s    = 1'b1;
               m_sof_s      = first_r;
               m_last_s     = 1'b1;
               first_s      = 1'b0;
               crc_s        = crc_fold_s;
               frm_crc_ok_s = (crc_fold_s == h1_r);
               frm_err_s    = 1'b0;
            end else begin
               frm_err_s    = 1'b1;           // no payload before EOF
            end
         end
         EV_TAKE: begin
            lfsr_s = keystream_s[31:16];
            cnt_s  = cnt_r + CNT_ONE;
            case (hcnt_r)
               2'd0: begin
                  h0_s   = descr_s;
                  hcnt_s = 2'd1;
               end
               2'd1: begin
                  h1_s   = descr_s;
                  hcnt_s = 2'd2;
               end
               default: begin
                  // Holdback full: the oldest dword is now known to be payload.
                  m_data_s  = h0_r;
                  m_valid_s = 1'b1;
                  m_sof_s   = first_r;
                  first_s   = 1'b0;
                  crc_s     = crc_fold_s;
                  h0_s      = h1_r;
                  h1_s      = descr_s;
                  hcnt_s    = 2'd2;
               end
            endcase
         end
         EV_TO_SKIP:  state_s = SKIP;
         EV_TO_FRAME: state_s = FRAME;
         default:     state_s = state_r;
      endcase
   end

endmodule

// File: tb/tb_sata_link_rx_deframer.sv
// Directed testbench for sata_link_rx_deframer. Expected payload, keystream
// and CRC dwords come from a bench-side Galois scrambler and bit-serial CRC.
module tb_sata_link_rx_deframer;

   localparam logic [31:0] SOF   = 32'h3737B57C;
   localparam logic [31:0] EOF   = 32'hD5D5B57C;
   localparam logic [31:0] CONT  = 32'h9999AA7C;
   localparam logic [31:0] SYNC  = 32'hB5B5957C;
   localparam logic [31:0] HOLD  = 32'hD5D5AA7C;
   localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
   localparam logic [31:0] POLY  = 32'h04C11DB7;
   localparam logic [31:0] CINIT = 32'h52325032;
   localparam int          MAXDW = 2049;

   logic        clk;
   logic        rst;
   logic [31:0] rx_data;
   logic [3:0]  rx_isk;
   logic        rx_valid;
   logic [31:0] m_data;
   logic        m_valid, m_sof, m_last, frm_done, frm_crc_ok, frm_err, busy;

   int n_cmp;
   int n_bad;

   logic [31:0] bq_data[$];
   logic        bq_sof[$];
   logic        bq_last[$];
   logic        dq_ok[$];
   logic        dq_err[$];

   logic [15:0] g;        // Galois scrambler state of the model
   logic [31:0] crc_m;    // model CRC over payload sent so far

   sata_link_rx_deframer dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_isk(rx_isk), .rx_valid(rx_valid),
      .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof), .m_last(m_last),
      .frm_done(frm_done), .frm_crc_ok(frm_crc_ok), .frm_err(frm_err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture output beats and status strobes away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         bq_data.push_back(m_data);
         bq_sof.push_back(m_sof);
         bq_last.push_back(m_last);
      end
      if (frm_done) begin
         dq_ok.push_back(frm_crc_ok);
         dq_err.push_back(frm_err);
      end
   end

   // Serial Galois scrambler: output bit is state[15], mask 0xA011.
   task automatic model_ks(output logic [31:0] k);
      k = 32'h0;
      for (int i = 0; i < 32; i++) begin
         k = {g[15], k[31:1]};
         g = g[15] ? ((g << 1) ^ 16'hA011) : (g << 1);
      end
   endtask

   function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [31:0] d);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int i = 31; i >= 0; i--) begin
         fb = r[31] ^ d[i];
         r  = {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      end
      return r;
   endfunction

   task automatic drive(input logic [31:0] d, input logic [3:0] k);
      @(negedge clk);
      rx_data = d; rx_isk = k; rx_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_data = 32'h0; rx_isk = 4'b0000; rx_valid = 1'b0;
      end
   endtask

   task automatic clear_q();
      bq_data.delete(); bq_sof.delete(); bq_last.delete();
      dq_ok.delete(); dq_err.delete();
   endtask

   task automatic start_frame();
      drive(SOF, 4'b0001);
      g = 16'hFFFF;
      crc_m = CINIT;
   endtask

   task automatic send_pay(input logic [31:0] w);
      logic [31:0] k;
      model_ks(k);
      drive(w ^ k, 4'b0000);
      crc_m = crc_model(crc_m, w);
   endtask

   task automatic send_crc(input logic [31:0] flip);
      logic [31:0] k;
      model_ks(k);
      drive(crc_m ^ flip ^ k, 4'b0000);
   endtask

   // Scrambled-zero payload dword given literally; the model keystream still steps.
   task automatic send_zero_literal();
      logic [31:0] k;
      model_ks(k);
      drive(32'hC2D2768D, 4'b0000);
      crc_m = crc_model(crc_m, 32'h0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(3);
      n_cmp++;
      if ({m_valid, m_sof, m_last, frm_done, frm_crc_ok, frm_err, busy} !== 7'b0) begin
         n_bad++; $display("FAIL reset_flags: got %b want 0000000",
                           {m_valid, m_sof, m_last, frm_done, frm_crc_ok, frm_err, busy});
      end
      n_cmp++;
      if (m_data !== 32'h0) begin
         n_bad++; $display("FAIL reset_data: got %h want 00000000", m_data);
      end
      drive(SOF, 4'b0001);
      idle(1);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++; $display("FAIL reset_holds: busy got %b want 0", busy);
      end
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_single(input logic [31:0] flip, input logic want_ok, input string nm);
      clear_q();
      start_frame();
      send_zero_literal();
      send_crc(flip);
      drive(EOF, 4'b0001);
      idle(4);
      n_cmp++;
      if (bq_data.size() !== 1) begin
         n_bad++; $display("FAIL %s_beats: got %0d want 1", nm, bq_data.size());
      end
      n_cmp++;
      if ({bq_data[0], bq_sof[0], bq_last[0]} !== {32'h0, 1'b1, 1'b1}) begin
         n_bad++; $display("FAIL %s_beat: got %h/%b%b want 00000000/11", nm,
                           bq_data[0], bq_sof[0], bq_last[0]);
      end
      n_cmp++;
      if ((dq_ok.size() !== 1) || ({dq_ok[0], dq_err[0]} !== {want_ok, 1'b0})) begin
         n_bad++; $display("FAIL %s_status: got n=%0d ok/err=%b%b want n=1 %b0", nm,
                           dq_ok.size(), dq_ok[0], dq_err[0], want_ok);
      end
   endtask

   task automatic test_interleave();
      logic [31:0] pay[3];
      pay[0] = 32'h11111111; pay[1] = 32'hDEADBEEF; pay[2] = 32'h0000FFFF;
      clear_q();
      start_frame();
      send_pay(pay[0]);
      drive(HOLD, 4'b0001);
      send_pay(pay[1]);
      drive(ALIGN, 4'b0001);
      @(negedge clk);
      rx_data = SOF; rx_isk = 4'b0001; rx_valid = 1'b0;   // invalid beat, must be ignored
      send_pay(pay[2]);
      drive(HOLD, 4'b0001);
      send_crc(32'h0);
      drive(EOF, 4'b0001);
      idle(4);
      n_cmp++;
      if (bq_data.size() !== 3) begin
         n_bad++; $display("FAIL ilv_beats: got %0d want 3", bq_data.size());
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({bq_data[i], bq_sof[i], bq_last[i]} !== {pay[i], (i == 0), (i == 2)}) begin
            n_bad++; $display("FAIL ilv_beat%0d: got %h/%b%b want %h/%b%b", i,
                              bq_data[i], bq_sof[i], bq_last[i], pay[i], (i == 0), (i == 2));
         end
      end
      n_cmp++;
      if ((dq_ok.size() !== 1) || ({dq_ok[0], dq_err[0]} !== 2'b10)) begin
         n_bad++; $display("FAIL ilv_status: got n=%0d ok/err=%b%b want n=1 10",
                           dq_ok.size(), dq_ok[0], dq_err[0]);
      end
      n_cmp++;
      if ((m_valid !== 1'b0) || (m_data !== pay[2])) begin
         n_bad++; $display("FAIL ilv_hold: got v=%b d=%h want v=0 d=%h", m_valid, m_data, pay[2]);
      end
   endtask

   task automatic test_cont();
      logic [31:0] pay[3];
      pay[0] = 32'hA5A5A5A5; pay[1] = 32'h01234567; pay[2] = 32'h89ABCDEF;
      clear_q();
      start_frame();
      send_pay(pay[0]);
      send_pay(pay[1]);
      drive(CONT, 4'b0001);
      for (int i = 0; i < 5; i++) drive(32'h5A5A0000 + 32'(i), 4'b0000);
      drive(HOLD, 4'b0001);
      send_pay(pay[2]);
      send_crc(32'h0);
      drive(EOF, 4'b0001);
      idle(4);
      n_cmp++;
      if (bq_data.size() !== 3) begin
         n_bad++; $display("FAIL cont_beats: got %0d want 3", bq_data.size());
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({bq_data[i], bq_sof[i], bq_last[i]} !== {pay[i], (i == 0), (i == 2)}) begin
            n_bad++; $display("FAIL cont_beat%0d: got %h/%b%b want %h/%b%b", i,
                              bq_data[i], bq_sof[i], bq_last[i], pay[i], (i == 0), (i == 2));
         end
      end
      n_cmp++;
      if ((dq_ok.size() !== 1) || ({dq_ok[0], dq_err[0]} !== 2'b10)) begin
         n_bad++; $display("FAIL cont_status: got n=%0d ok/err=%b%b want n=1 10",
                           dq_ok.size(), dq_ok[0], dq_err[0]);
      end
   endtask

   task automatic test_sof_restart();
      clear_q();
      start_frame();
      send_pay(32'h13579BDF);
      send_pay(32'h2468ACE0);
      start_frame();
      send_zero_literal();
      send_crc(32'h0);
      drive(EOF, 4'b0001);
      idle(4);
      n_cmp++;
      if ((bq_data.size() !== 1) || ({bq_data[0], bq_sof[0], bq_last[0]} !== {32'h0, 1'b1, 1'b1})) begin
         n_bad++; $display("FAIL restart_beat: got n=%0d %h/%b%b want n=1 00000000/11",
                           bq_data.size(), bq_data[0], bq_sof[0], bq_last[0]);
      end
      n_cmp++;
      if ((dq_ok.size() !== 2) || ({dq_ok[0], dq_err[0], dq_ok[1], dq_err[1]} !== 4'b0110)) begin
         n_bad++; $display("FAIL restart_status: got n=%0d %b%b,%b%b want n=2 01,10",
                           dq_ok.size(), dq_ok[0], dq_err[0], dq_ok[1], dq_err[1]);
      end
   endtask

   task automatic test_short_and_sync();
      clear_q();
      start_frame();
      drive(EOF, 4'b0001);
      idle(3);
      start_frame();
      send_pay(32'hCAFEF00D);
      drive(EOF, 4'b0001);
      idle(3);
      n_cmp++;
      if ((dq_ok.size() !== 2) || ({dq_ok[0], dq_err[0], dq_ok[1], dq_err[1]} !== 4'b0101)) begin
         n_bad++; $display("FAIL short_status: got n=%0d %b%b,%b%b want n=2 01,01",
                           dq_ok.size(), dq_ok[0], dq_err[0], dq_ok[1], dq_err[1]);
      end
      n_cmp++;
      if (bq_data.size() !== 0) begin
         n_bad++; $display("FAIL short_beats: got %0d want 0", bq_data.size());
      end
      clear_q();
      start_frame();
      send_pay(32'h00000001);
      send_pay(32'h00000002);
      send_pay(32'h00000003);
      drive(SYNC, 4'b0001);
      idle(3);
      n_cmp++;
      if ((bq_data.size() !== 1) || ({bq_data[0], bq_sof[0], bq_last[0]} !== {32'h1, 1'b1, 1'b0})) begin
         n_bad++; $display("FAIL sync_beat: got n=%0d %h/%b%b want n=1 00000001/10",
                           bq_data.size(), bq_data[0], bq_sof[0], bq_last[0]);
      end
      n_cmp++;
      if ((dq_ok.size() !== 1) || ({dq_ok[0], dq_err[0]} !== 2'b01) || (busy !== 1'b0)) begin
         n_bad++; $display("FAIL sync_status: got n=%0d ok/err=%b%b busy=%b want n=1 01 busy=0",
                           dq_ok.size(), dq_ok[0], dq_err[0], busy);
      end
   endtask

   task automatic test_code_err();
      clear_q();
      drive(32'h12345678, 4'b0010);       // in IDLE: ignored
      idle(2);
      n_cmp++;
      if (dq_ok.size() !== 0) begin
         n_bad++; $display("FAIL codeerr_idle: got %0d strobes want 0", dq_ok.size());
      end
      start_frame();
      send_pay(32'hFFFF0000);
      send_pay(32'h0000FFFF);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++; $display("FAIL codeerr_busy: got %b want 1", busy);
      end
      drive(32'h12345678, 4'b0010);
      idle(3);
      n_cmp++;
      if ((dq_ok.size() !== 1) || ({dq_ok[0], dq_err[0]} !== 2'b01) || (bq_data.size() !== 0)) begin
         n_bad++; $display("FAIL codeerr_status: got n=%0d ok/err=%b%b beats=%0d want n=1 01 beats=0",
                           dq_ok.size(), dq_ok[0], dq_err[0], bq_data.size());
      end
   endtask

   task automatic test_length(input int n_pay, input logic close, input string nm);
      int bad;
      int want_beats;
      clear_q();
      start_frame();
      for (int i = 0; i < n_pay; i++) send_pay(32'(i) * 32'h9E3779B9);
      if (close) begin
         send_crc(32'h0);
         drive(EOF, 4'b0001);
         want_beats = n_pay;
      end else begin
         want_beats = MAXDW - 2;
      end
      idle(4);
      n_cmp++;
      if (bq_data.size() !== want_beats) begin
         n_bad++; $display("FAIL %s_beats: got %0d want %0d", nm, bq_data.size(), want_beats);
      end
      bad = 0;
      for (int i = 0; i < bq_data.size(); i++) begin
         if ({bq_data[i], bq_sof[i], bq_last[i]} !==
             {32'(i) * 32'h9E3779B9, (i == 0), (close && (i == want_beats - 1))}) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++; $display("FAIL %s_payload: got %0d wrong beats want 0", nm, bad);
      end
      n_cmp++;
      if ((dq_ok.size() !== 1) || ({dq_ok[0], dq_err[0]} !== (close ? 2'b10 : 2'b01))) begin
         n_bad++; $display("FAIL %s_status: got n=%0d ok/err=%b%b want n=1 %b",
                           nm, dq_ok.size(), dq_ok[0], dq_err[0], (close ? 2'b10 : 2'b01));
      end
   endtask

   task automatic test_rst_mid();
      clear_q();
      start_frame();
      send_pay(32'h0BADF00D);
      send_pay(32'h0DEFACED);
      send_pay(32'h00C0FFEE);
      @(negedge clk);
      rst = 1'b1; rx_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({m_data, m_valid, m_sof, m_last, frm_done, frm_crc_ok, frm_err, busy} !== 39'h0) begin
         n_bad++; $display("FAIL rstmid_outputs: got %h/%b want all zero", m_data,
                           {m_valid, m_sof, m_last, frm_done, frm_crc_ok, frm_err, busy});
      end
      rst = 1'b0;
      idle(4);
      n_cmp++;
      if (dq_ok.size() !== 0) begin
         n_bad++; $display("FAIL rstmid_done: got %0d strobes want 0", dq_ok.size());
      end
   endtask

   task automatic test_back_to_back();
      clear_q();
      start_frame();
      send_pay(32'hAAAA5555);
      send_pay(32'h5555AAAA);
      send_crc(32'h0);
      drive(EOF, 4'b0001);
      start_frame();
      send_pay(32'h87654321);
      send_crc(32'h0);
      drive(EOF, 4'b0001);
      idle(4);
      n_cmp++;
      if ({bq_data.size(), bq_data[0], bq_sof[0], bq_last[0], bq_data[1], bq_sof[1], bq_last[1],
           bq_data[2], bq_sof[2], bq_last[2]} !==
          {32'd3, 32'hAAAA5555, 2'b10, 32'h5555AAAA, 2'b01, 32'h87654321, 2'b11}) begin
         n_bad++; $display("FAIL b2b_beats: got n=%0d %h/%b%b %h/%b%b %h/%b%b want 3 aaaa5555/10 5555aaaa/01 87654321/11",
                           bq_data.size(), bq_data[0], bq_sof[0], bq_last[0], bq_data[1], bq_sof[1],
                           bq_last[1], bq_data[2], bq_sof[2], bq_last[2]);
      end
      n_cmp++;
      if ((dq_ok.size() !== 2) || ({dq_ok[0], dq_err[0], dq_ok[1], dq_err[1]} !== 4'b1010)) begin
         n_bad++; $display("FAIL b2b_status: got n=%0d %b%b,%b%b want n=2 10,10",
                           dq_ok.size(), dq_ok[0], dq_err[0], dq_ok[1], dq_err[1]);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      rx_data = 32'h0;
      rx_isk = 4'b0000;
      rx_valid = 1'b0;
      g = 16'hFFFF;
      crc_m = CINIT;
      test_reset();
      test_single(32'h0, 1'b1, "single");
      test_interleave();
      test_cont();
      test_single(32'h00000100, 1'b0, "badcrc");
      test_sof_restart();
      test_short_and_sync();
      test_code_err();
      test_length(MAXDW + 1, 1'b0, "overflow");
      test_length(MAXDW - 1, 1'b1, "maxlen");
      test_rst_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
